// File: rtl/gates_exhaustive_driver.sv
// Exhaustive stimulus sweeper for small combinational self-checkers.
// Drives every vector in ascending order, samples fail_i after a settle window.
module gates_exhaustive_driver #(
    parameter int W      = 2,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [W-1:0] stim_o,
    input  logic         fail_i,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [W:0]   fail_cnt,
    output logic         first_fail_vld,
    output logic [W-1:0] first_fail_vec
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [7:0]   SET_INIT = 8'(SETTLE);
    localparam logic [W-1:0] LAST_VEC = {W{1'b1}};

    state_t     r_state;
    logic [7:0] r_settle;
    logic [W:0] w_cnt_nxt;

    // Count including the vector being sampled this cycle
    assign w_cnt_nxt = fail_cnt + {{W{1'b0}}, fail_i};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_settle       <= 8'd0;
            stim_o         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_cnt       <= '0;
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_state        <= S_RUN;
                        busy           <= 1'b1;
                        stim_o         <= '0;
                        r_settle       <= SET_INIT;
                        fail_cnt       <= '0;
                        first_fail_vld <= 1'b0;
                        first_fail_vec <= '0;
                        pass           <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (r_settle != 8'd0) begin
                        r_settle <= r_settle - 8'd1;
                    end else begin
                        if (fail_i) begin
                            fail_cnt <= w_cnt_nxt;
                            if (!first_fail_vld) begin
                                first_fail_vld <= 1'b1;
                                first_fail_vec <= stim_o;
                            end
                        end
                        if (stim_o == LAST_VEC) begin
                            r_state <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            stim_o  <= '0;
                            pass    <= (w_cnt_nxt == '0);
                        end else begin
                            stim_o   <= stim_o + 1'b1;
                            r_settle <= SET_INIT;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gates_exhaustive_driver.sv
// Bench for gates_exhaustive_driver: three configurations, fail_i from a
// per-instance fault mask indexed by the stimulus.
module tb_gates_exhaustive_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic       start0 = 0, start1 = 0, start2 = 0;
    logic [7:0] mask0 = 0, mask1 = 0, mask2 = 0;

    logic [1:0] stim0, vec0;
    logic [2:0] cnt0;
    logic       busy0, done0, pass0, vld0, fail0;
    logic [1:0] stim1, vec1;
    logic [2:0] cnt1;
    logic       busy1, done1, pass1, vld1, fail1;
    logic [2:0] stim2, vec2;
    logic [3:0] cnt2;
    logic       busy2, done2, pass2, vld2, fail2;

    assign fail0 = mask0[stim0];
    assign fail1 = mask1[stim1];
    assign fail2 = mask2[stim2];

    gates_exhaustive_driver #(.W(2), .SETTLE(1)) u0 (
        .clk(clk), .rst(rst), .start(start0), .stim_o(stim0),
        .fail_i(fail0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_cnt(cnt0), .first_fail_vld(vld0), .first_fail_vec(vec0));

    gates_exhaustive_driver #(.W(2), .SETTLE(0)) u1 (
        .clk(clk), .rst(rst), .start(start1), .stim_o(stim1),
        .fail_i(fail1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_cnt(cnt1), .first_fail_vld(vld1), .first_fail_vec(vec1));

    gates_exhaustive_driver #(.W(3), .SETTLE(2)) u2 (
        .clk(clk), .rst(rst), .start(start2), .stim_o(stim2),
        .fail_i(fail2), .busy(busy2), .done(done2), .pass(pass2),
        .fail_cnt(cnt2), .first_fail_vld(vld2), .first_fail_vec(vec2));

    typedef struct {
        int stim;
        bit busy;
        bit done;
        bit pss;
        bit vld;
        int cnt;
        int vec;
    } obs_t;

    typedef struct {
        int         d;
        logic [7:0] mask;
        int         restart;
        int         cnt;
        bit         vld;
        int         vec;
        bit         pss;
    } vec_t;

    function automatic obs_t obs(input int d);
        obs_t o;
        case (d)
            0: o = '{int'(stim0), busy0, done0, pass0, vld0, int'(cnt0), int'(vec0)};
            1: o = '{int'(stim1), busy1, done1, pass1, vld1, int'(cnt1), int'(vec1)};
            default: o = '{int'(stim2), busy2, done2, pass2, vld2, int'(cnt2), int'(vec2)};
        endcase
        return o;
    endfunction

    function automatic int width_of(input int d);
        return (d == 2) ? 3 : 2;
    endfunction

    function automatic int settle_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 2);
    endfunction

    task automatic set_start(input int d, input logic v);
        case (d)
            0: start0 = v;
            1: start1 = v;
            default: start2 = v;
        endcase
    endtask

    task automatic set_mask(input int d, input logic [7:0] m);
        case (d)
            0: mask0 = m;
            1: mask1 = m;
            default: mask2 = m;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Launch a sweep and follow it cycle by cycle; optional stray start at cycle 'restart'
    task automatic run_sweep(input int d, input int restart);
        int n, sp, errs;
        obs_t o;
        n = 1 << width_of(d);
        sp = settle_of(d) + 1;
        errs = 0;
        set_start(d, 1'b1);
        tick();
        set_start(d, 1'b0);
        for (int k = 0; k < n * sp; k++) begin
            o = obs(d);
            if (o.stim != k / sp || !o.busy || o.done) errs++;
            set_start(d, k == restart);
            tick();
        end
        set_start(d, 1'b0);
        chk("sweep_sequence_errors", errs, 0);
        o = obs(d);
        chk("busy_low_at_end", int'(o.busy), 0);
        chk("done_pulse", int'(o.done), 1);
        chk("stim_back_to_zero", o.stim, 0);
        tick();
        o = obs(d);
        chk("done_single_cycle", int'(o.done), 0);
        chk("idle_after_done", int'(o.busy), 0);
    endtask

    task automatic check_result(input int d, input int cnt, input bit vld,
                                input int vec, input bit pss);
        obs_t o;
        o = obs(d);
        chk("fail_cnt", o.cnt, cnt);
        chk("first_fail_vld", int'(o.vld), int'(vld));
        chk("first_fail_vec", o.vec, vec);
        chk("pass", int'(o.pss), int'(pss));
    endtask

    vec_t tbl[5];

    initial begin
        obs_t o;
        int   errs;
        int   d, n, ecnt, efirst;
        logic [7:0] m;

        tbl[0] = '{0, 8'h00, -1, 0, 1'b0, 0, 1'b1};
        tbl[1] = '{0, 8'h08, -1, 1, 1'b1, 3, 1'b0};
        tbl[2] = '{1, 8'h0F, -1, 4, 1'b1, 0, 1'b0};
        tbl[3] = '{2, 8'h60,  5, 2, 1'b1, 5, 1'b0};
        tbl[4] = '{2, 8'h81, -1, 2, 1'b1, 0, 1'b0};

        #3;
        o = obs(0);
        chk("reset_stim", o.stim, 0);
        chk("reset_busy", int'(o.busy), 0);
        chk("reset_pass", int'(o.pss), 0);
        chk("reset_cnt", o.cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            set_mask(tbl[i].d, tbl[i].mask);
            run_sweep(tbl[i].d, tbl[i].restart);
            check_result(tbl[i].d, tbl[i].cnt, tbl[i].vld, tbl[i].vec, tbl[i].pss);
            tick();
            tick();
            o = obs(tbl[i].d);
            chk("cnt_stable_in_idle", o.cnt, tbl[i].cnt);
        end

        // Random fault masks against a popcount / lowest-set-bit model
        for (int r = 0; r < 8; r++) begin
            d = $urandom_range(0, 2);
            n = 1 << width_of(d);
            m = 8'($urandom) & 8'((1 << n) - 1);
            ecnt = 0;
            efirst = -1;
            for (int v = 0; v < n; v++) begin
                if (m[v]) begin
                    ecnt++;
                    if (efirst < 0) efirst = v;
                end
            end
            set_mask(d, m);
            run_sweep(d, -1);
            check_result(d, ecnt, efirst >= 0, (efirst < 0) ? 0 : efirst, ecnt == 0);
        end

        // Asynchronous reset in the middle of a sweep
        mask0 = 8'h0F;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        o = obs(0);
        chk("pre_reset_stim", o.stim, 2);
        chk("pre_reset_cnt", o.cnt, 2);
        #2;
        rst = 1'b1;
        #1;
        o = obs(0);
        chk("async_rst_stim", o.stim, 0);
        chk("async_rst_busy", int'(o.busy), 0);
        chk("async_rst_cnt", o.cnt, 0);
        chk("async_rst_vld", int'(o.vld), 0);
        @(negedge clk);
        rst = 1'b0;
        errs = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done0 || busy0) errs++;
        end
        chk("no_done_after_reset", errs, 0);
        mask0 = 8'h00;
        run_sweep(0, -1);
        check_result(0, 0, 1'b0, 0, 1'b1);

        // Start held high: back-to-back relaunch
        mask1 = 8'h0F;
        start1 = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) tick();
        chk("b2b_done", int'(done1), 1);
        chk("b2b_cnt_first", int'(cnt1), 4);
        chk("b2b_pass_first", int'(pass1), 0);
        tick();
        chk("b2b_idle_busy", int'(busy1), 0);
        chk("b2b_idle_done", int'(done1), 0);
        mask1 = 8'h00;
        tick();
        chk("b2b_relaunch_busy", int'(busy1), 1);
        chk("b2b_relaunch_cnt", int'(cnt1), 0);
        chk("b2b_relaunch_vld", int'(vld1), 0);
        chk("b2b_relaunch_pass", int'(pass1), 0);
        start1 = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("b2b_done2", int'(done1), 1);
        chk("b2b_pass_second", int'(pass1), 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gates_exhaustive_driver.md
Name: gates_exhaustive_driver

Overview:
- Sequential stimulus-and-check engine for small self-checking combinational blocks, such as the MUX2X1-derived gate checkers.
- Those blocks take inputs and report a `fail` bit; this block is the other end of that interface. It drives every input combination in ascending order, waits a settle window, then samples the DUT's `fail` output.
- Accumulates a failure count, captures the first failing vector, and reports pass/done.
- Sits in the self-test harness alongside the combinational checkers.

Parameters:
- W, 2, stimulus width; the sweep covers 0 .. 2^W-1. Legal range 1..16.
- SETTLE, 1, extra cycles each vector is held before `fail_i` is sampled. Legal range 0..255.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  begin a sweep; sampled only in IDLE.
- stim_o  output  W  stimulus to the DUT. Bit 0 drives input a, bit 1 drives input b, and so on.
- fail_i  input  1  DUT fail flag (combinational from stim_o).
- busy  output  1  high while a sweep is in progress.
- done  output  1  single-cycle pulse when the sweep completes.
- pass  output  1  registered result of the last completed sweep: 1 means zero failures.
- fail_cnt  output  W+1  number of vectors with fail_i=1 in the last or current sweep.
- first_fail_vld  output  1  a failing vector has been captured.
- first_fail_vec  output  W  lowest failing vector of the sweep.

Behaviour:
- Reset values (asynchronous, while rst=1):
  - state=IDLE
  - stim_o=0, busy=0, done=0, pass=0, fail_cnt=0, first_fail_vld=0, first_fail_vec=0
  - internal settle counter=0
- Reset mid-sweep aborts immediately to these values. No done pulse is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy=0; stim_o holds 0.
  - start=1 at an edge causes, at that edge: state->RUN, busy=1, stim_o=0, settle counter=SETTLE, fail_cnt=0, first_fail_vld=0, first_fail_vec=0, pass=0.
- RUN:
  - Each vector is held on stim_o for exactly SETTLE+1 cycles.
  - When settle counter != 0: decrement it.
  - When settle counter == 0, fail_i is sampled that cycle, and at the following edge:
    - If fail_i=1: fail_cnt increments. If first_fail_vld=0, first_fail_vec<=stim_o and first_fail_vld<=1.
    - If stim_o == 2^W-1: state->DONE, busy<=0, stim_o<=0.
    - Otherwise: stim_o<=stim_o+1 and settle counter<=SETTLE.
- DONE:
  - Lasts exactly 1 cycle, with done=1, then returns to IDLE.
  - pass is registered on entry to DONE: pass = (final fail_cnt == 0). Hold pass until the next accepted start or reset.
- Latency: with start accepted at edge E0, busy rises at E0 and falls at E(2^W*(SETTLE+1)). done is high for the cycle that follows that edge.
- start is ignored in RUN and DONE; there is no queuing. start held high continuously re-launches a sweep on the first IDLE cycle.
- fail_cnt width W+1 holds the maximum value 2^W without wrap. stim_o wrap from 2^W-1 does not occur within a sweep.
- fail_cnt, first_fail_* and pass remain stable in IDLE for readout.
- fail_i is only sampled in RUN with the settle counter at 0. Values at all other times are don't-care.

Test Plan:
- W=2, SETTLE=1, fail_i driven by a correct gates-from-mux checker; pulse start:
  - stim_o steps 0,0,1,1,2,2,3,3; busy high for 8 cycles.
  - done pulse follows; pass=1, fail_cnt=0, first_fail_vld=0.
- W=2, SETTLE=1, fault model fail_i = stim_o[0] & stim_o[1]:
  - fail_cnt=1, first_fail_vec=3, first_fail_vld=1, pass=0.
- W=2, SETTLE=0, fail_i tied 1:
  - busy for 4 cycles; fail_cnt=4 (=3'b100); first_fail_vec=0; pass=0.
- W=3, SETTLE=2, fail_i = (stim_o==5 or stim_o==6); start pulsed again at cycle 5 of the sweep:
  - The second start is ignored; busy stays high for 24 cycles.
  - fail_cnt=2, first_fail_vec=5.
- Reset asserted while stim_o=2 mid-sweep:
  - All outputs return to reset values asynchronously; no done pulse.
  - A start after reset release runs a full clean sweep.
- Back-to-back runs with start held high:
  - done pulse; one IDLE cycle; the new sweep starts.
  - fail_cnt and first_fail are cleared at the relaunch edge; pass is cleared then recomputed.
